// File: rtl/sprite_line_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_line_scheduler
//
// Prepares one scan line of sprite pixels during horizontal blank. On each
// line_start it walks the sprite parameter table from the highest index down
// to index 0. It reads each parameter word and tests whether the sprite
// covers the requested line. For every covering sprite it streams one sprite
// row out of sprite RAM into the line buffer. Lower-index sprites are written
// later, so they win wherever sprites overlap.
//
// Ports
//   clk_clk         in   system clock, all state on rising edge
//   reset_reset     in   asynchronous active-high reset
//   line_start      in   one-cycle pulse at start of horizontal blank
//   next_line       in   [9:0] scan line to prepare (sampled with line_start)
//   spr_param_addr  out  [2:0] sprite index for the parameter read
//   spr_param_data  in   [31:0] parameter word, one cycle after the address
//                        bit31 enable, [25:16] y, [9:0] x
//   spr_sel         out  [2:0] sprite RAM select
//   spr_chipselect  out  sprite RAM chipselect
//   spr_clken       out  sprite RAM clock enable (same as chipselect)
//   spr_addr        out  [10:0] sprite RAM word address {row, col}
//   spr_readdata    in   [15:0] RGB565 pixel, one cycle after the address
//   lb_we           out  line-buffer write strobe
//   lb_addr         out  [9:0] line-buffer pixel column
//   lb_data         out  [15:0] line-buffer pixel
//   busy            out  high whenever not idle
//   done            out  one-cycle pulse when the line is prepared
//   overrun         out  sticky: line_start seen while busy
// -----------------------------------------------------------------------------
module sprite_line_scheduler #(
  parameter int          NUM_SPR     = 8,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 64,
  parameter int          LINE_W      = 640,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  output logic [2:0]  spr_param_addr,
  input  logic [31:0] spr_param_data,
  output logic [2:0]  spr_sel,
  output logic        spr_chipselect,
  output logic        spr_clken,
  output logic [10:0] spr_addr,
  input  logic [15:0] spr_readdata,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [15:0] lb_data,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PARAM = 3'd1,
    CHECK = 3'd2,
    FETCH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [9:0]  line;
  logic [2:0]  idx;
  logic [5:0]  row;
  logic [4:0]  col;
  logic [9:0]  xpos;
  logic        wr_pend;
  logic        in_range;
  logic        overrun_flag;

  logic        ld_line;
  logic        ld_hit;
  logic        dec_idx;
  logic        inc_col;

  logic [10:0] diff;
  logic        hit;
  logic [10:0] sum;
  logic        unused_param_bits;

  // Line minus sprite top at 11 bits: bit 10 set means the line is above the
  // sprite, so a large y never wraps around into a hit.
  assign diff = {1'b0, line} - {1'b0, spr_param_data[25:16]};
  assign hit  = spr_param_data[31] & ~diff[10] & (diff < 11'(SPR_H));
  assign sum  = {1'b0, xpos} + {6'b000000, col};

  assign unused_param_bits = ^{spr_param_data[30:26], spr_param_data[15:10]};

  // State register.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    ld_line   = 1'b0;
    ld_hit    = 1'b0;
    dec_idx   = 1'b0;
    inc_col   = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          state_nxt = PARAM;
          ld_line   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      PARAM: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (hit) begin
          state_nxt = FETCH;
          ld_hit    = 1'b1;
        end else if (idx == 3'd0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = PARAM;
          dec_idx   = 1'b1;
        end
      end
      FETCH: begin
        inc_col = 1'b1;
        if (col == 5'(SPR_W - 1)) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        // Same next-sprite decision as a CHECK miss.
        if (idx == 3'd0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = PARAM;
          dec_idx   = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Line, sprite index, row/column walk and line-buffer pipeline registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      line     <= 10'd0;
      idx      <= 3'd0;
      row      <= 6'd0;
      col      <= 5'd0;
      xpos     <= 10'd0;
      wr_pend  <= 1'b0;
      in_range <= 1'b0;
      lb_addr  <= 10'd0;
    end else begin
      if (ld_line) begin
        line <= next_line;
        idx  <= 3'(NUM_SPR - 1);
      end else if (dec_idx) begin
        idx <= idx - 3'd1;
      end
      if (ld_hit) begin
        row  <= diff[5:0];
        xpos <= spr_param_data[9:0];
        col  <= 5'd0;
      end else if (inc_col) begin
        col <= col + 5'd1;
      end
      // The RAM answers one cycle after the address, so the matching column
      // and its visibility are pipelined by one cycle alongside it.
      wr_pend <= (state == FETCH);
      if (state == FETCH) begin
        lb_addr  <= sum[9:0];
        in_range <= (sum < 11'(LINE_W));
      end
    end
  end

  // Sticky overrun flag; only reset clears it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      overrun_flag <= 1'b0;
    end else if (line_start && (state != IDLE)) begin
      overrun_flag <= 1'b1;
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign overrun        = overrun_flag;
  // idx is loaded only on entry to PARAM and reaches 0 before DONE, so it is
  // already 0 while idle.
  assign spr_param_addr = idx;
  assign spr_sel        = idx;
  assign spr_chipselect = (state == FETCH);
  assign spr_clken      = (state == FETCH);
  assign spr_addr       = (state == FETCH) ? {row, col} : 11'd0;
  assign lb_data        = wr_pend ? spr_readdata : 16'h0000;
  assign lb_we          = wr_pend & in_range & (spr_readdata != TRANSPARENT);

endmodule

// File: tb/tb_sprite_line_scheduler.sv
module tb_sprite_line_scheduler;

  localparam logic [15:0] TRANSP = 16'hF81F;

  logic        clk_clk;
  logic        reset_reset;
  logic        line_start;
  logic [9:0]  next_line;
  logic [2:0]  spr_param_addr;
  logic [31:0] spr_param_data;
  logic [2:0]  spr_sel;
  logic        spr_chipselect;
  logic        spr_clken;
  logic [10:0] spr_addr;
  logic [15:0] spr_readdata;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [15:0] lb_data;
  logic        busy;
  logic        done;
  logic        overrun;

  sprite_line_scheduler dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .line_start     (line_start),
    .next_line      (next_line),
    .spr_param_addr (spr_param_addr),
    .spr_param_data (spr_param_data),
    .spr_sel        (spr_sel),
    .spr_chipselect (spr_chipselect),
    .spr_clken      (spr_clken),
    .spr_addr       (spr_addr),
    .spr_readdata   (spr_readdata),
    .lb_we          (lb_we),
    .lb_addr        (lb_addr),
    .lb_data        (lb_data),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Stimulus memories: parameter table and sprite pixel source.
  logic [31:0] pmem [8];
  int          pix_mode;

  function automatic logic [15:0] pix(input logic [2:0] s, input logic [10:0] a);
    logic [15:0] p;
    case (pix_mode)
      1:       p = 16'h1234;
      2:       p = (s == 3'd0 && a[0] == 1'b0) ? TRANSP : {2'b00, s, a};
      default: p = {2'b00, s, a};
    endcase
    return p;
  endfunction

  always @(posedge clk_clk) spr_param_data <= pmem[spr_param_addr];
  always @(posedge clk_clk) if (spr_chipselect) spr_readdata <= pix(spr_sel, spr_addr);

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observations collected while a line is being prepared.
  int          cyc, done_at, n_wr, n_cs, first_addr, first_lb, last_lb;
  int          sel_exp, sel_bad, side_bad;
  logic [15:0] lbuf [640];
  bit          written [640];

  task automatic run_line(input logic [9:0] ln, input int ls_at, input logic [9:0] ls_line);
    n_wr = 0; n_cs = 0; sel_bad = 0; side_bad = 0;
    done_at = -1; first_addr = -1; first_lb = -1; last_lb = -1;
    for (int i = 0; i < 640; i++) begin
      lbuf[i] = 16'h0000;
      written[i] = 1'b0;
    end
    @(negedge clk_clk);
    line_start = 1'b1;
    next_line  = ln;
    @(negedge clk_clk);
    line_start = 1'b0;
    cyc = 1;
    while (done_at < 0 && cyc < 400) begin
      if (!busy) side_bad++;
      if (spr_clken !== spr_chipselect) side_bad++;
      if (spr_chipselect) begin
        n_cs++;
        if (first_addr < 0) first_addr = int'(spr_addr);
        if (int'(spr_sel) != sel_exp) sel_bad++;
      end
      if (lb_we) begin
        n_wr++;
        if (first_lb < 0) first_lb = int'(lb_addr);
        last_lb = int'(lb_addr);
        if (lb_addr < 10'd640) begin
          lbuf[lb_addr] = lb_data;
          written[lb_addr] = 1'b1;
        end
      end
      if (done) done_at = cyc;
      if (cyc == ls_at) begin
        line_start = 1'b1;
        next_line  = ls_line;
      end else begin
        line_start = 1'b0;
      end
      @(negedge clk_clk);
      cyc++;
    end
    line_start = 1'b0;
  endtask

  typedef struct {
    int spr; int en; int y; int x; int ln; int mode;
    int done_cyc; int nwr; int ncs; int row; int first_lb; int last_lb;
  } vec_t;

  vec_t vt [11];

  function automatic logic [31:0] pword(input int en, input int y, input int x);
    logic [9:0] yy;
    logic [9:0] xx;
    yy = 10'(y);
    xx = 10'(x);
    return {en[0], 5'b00000, yy, 6'b000000, xx};
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, overrun, lb_we, spr_chipselect, spr_clken,
                spr_addr, spr_sel, spr_param_addr, lb_addr, lb_data});
  endfunction

  initial begin
    int bad;
    int c;
    logic [15:0] e;
    n_vec = 0; n_err = 0;
    reset_reset = 1'b1; line_start = 1'b0; next_line = 10'd0; pix_mode = 0;
    for (int i = 0; i < 8; i++) pmem[i] = 32'h0;

    //          spr en  y    x    ln  md done nwr ncs row  flb  llb
    vt[0]  = '{0, 0, 100,   0, 100, 0, 17,  0,  0, -1,  -1,  -1};
    vt[1]  = '{3, 1,  90, 200, 100, 0, 50, 32, 32, 10, 200, 231};
    vt[2]  = '{0, 1,   0, 620,   5, 1, 50, 20, 32,  5, 620, 639};
    vt[3]  = '{2, 1, 100,   0,  99, 0, 17,  0,  0, -1,  -1,  -1};
    vt[4]  = '{2, 1, 100,   0, 100, 0, 50, 32, 32,  0,   0,  31};
    vt[5]  = '{2, 1, 100,   0, 163, 0, 50, 32, 32, 63,   0,  31};
    vt[6]  = '{2, 1, 100,   0, 164, 0, 17,  0,  0, -1,  -1,  -1};
    vt[7]  = '{6, 1,1000,   0,   5, 0, 17,  0,  0, -1,  -1,  -1};
    vt[8]  = '{7, 1,   0, 639,  63, 0, 50,  1, 32, 63, 639, 639};
    vt[9]  = '{4, 1,   0,1000,   0, 0, 50,  0, 32,  0,  -1,  -1};
    vt[10] = '{1, 1, 500, 608, 520, 0, 50, 32, 32, 20, 608, 639};

    repeat (3) @(negedge clk_clk);
    chk("reset_outputs", out_vec(), 64'd0);
    reset_reset = 1'b0;
    @(negedge clk_clk);

    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < 8; i++) pmem[i] = 32'h0;
      pmem[vt[v].spr] = pword(vt[v].en, vt[v].y, vt[v].x);
      pix_mode = vt[v].mode;
      sel_exp  = vt[v].spr;
      run_line(10'(vt[v].ln), 0, 10'd0);
      chk($sformatf("v%0d_done_cycle", v), 64'(done_at), 64'(vt[v].done_cyc));
      chk($sformatf("v%0d_lb_writes", v), 64'(n_wr), 64'(vt[v].nwr));
      chk($sformatf("v%0d_ram_reads", v), 64'(n_cs), 64'(vt[v].ncs));
      chk($sformatf("v%0d_sideband", v), 64'(side_bad), 64'd0);
      chk($sformatf("v%0d_idle_after", v), 64'({busy, done}), 64'd0);
      if (vt[v].row >= 0) begin
        chk($sformatf("v%0d_first_spr_addr", v), 64'(first_addr), 64'(vt[v].row * 32));
        chk($sformatf("v%0d_spr_sel", v), 64'(sel_bad), 64'd0);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
          c = vt[v].x + k;
          e = pix(3'(vt[v].spr), 11'(vt[v].row * 32 + k));
          if (c < 640 && (!written[c] || lbuf[c] !== e)) bad++;
        end
        chk($sformatf("v%0d_lb_content", v), 64'(bad), 64'd0);
      end
      if (vt[v].nwr > 0) begin
        chk($sformatf("v%0d_first_lb", v), 64'(first_lb), 64'(vt[v].first_lb));
        chk($sformatf("v%0d_last_lb", v), 64'(last_lb), 64'(vt[v].last_lb));
      end
    end
    chk("overrun_clear", 64'(overrun), 64'd0);

    // All eight sprites hit: 8 * 35 + DONE.
    for (int i = 0; i < 8; i++) pmem[i] = pword(1, 0, 0);
    pix_mode = 0;
    run_line(10'd0, 0, 10'd0);
    chk("allhit_done_cycle", 64'(done_at), 64'd281);
    chk("allhit_lb_writes", 64'(n_wr), 64'd256);
    bad = 0;
    for (int k = 0; k < 32; k++) if (lbuf[k] !== pix(3'd0, 11'(k))) bad++;
    chk("allhit_sprite0_wins", 64'(bad), 64'd0);

    // Sprites 5 and 0 overlap at x=10; sprite 0 even columns are transparent.
    for (int i = 0; i < 8; i++) pmem[i] = 32'h0;
    pmem[5] = pword(1, 0, 10);
    pmem[0] = pword(1, 0, 10);
    pix_mode = 2;
    run_line(10'd0, 0, 10'd0);
    chk("overlap_done_cycle", 64'(done_at), 64'd83);
    chk("overlap_lb_writes", 64'(n_wr), 64'd48);
    chk("overlap_first_lb", 64'(first_lb), 64'd10);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      e = (k % 2 == 0) ? pix(3'd5, 11'(k)) : pix(3'd0, 11'(k));
      if (lbuf[10 + k] !== e) bad++;
    end
    chk("overlap_content", 64'(bad), 64'd0);

    // line_start during FETCH: ignored, overrun set, line unchanged.
    for (int i = 0; i < 8; i++) pmem[i] = 32'h0;
    pmem[3] = pword(1, 90, 200);
    pix_mode = 0;
    sel_exp = 3;
    run_line(10'd100, 20, 10'd0);
    chk("ovr_done_cycle", 64'(done_at), 64'd50);
    chk("ovr_lb_writes", 64'(n_wr), 64'd32);
    chk("ovr_first_spr_addr", 64'(first_addr), 64'd320);
    chk("ovr_flag", 64'(overrun), 64'd1);
    pmem[3] = 32'h0;
    run_line(10'd100, 0, 10'd0);
    chk("ovr_next_line_done", 64'(done_at), 64'd17);
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Reset asserted mid-FETCH clears everything at once.
    pmem[3] = pword(1, 90, 200);
    @(negedge clk_clk);
    line_start = 1'b1;
    next_line  = 10'd100;
    @(negedge clk_clk);
    line_start = 1'b0;
    repeat (19) @(negedge clk_clk);
    chk("rst_pre_fetch", 64'(spr_chipselect), 64'd1);
    #1 reset_reset = 1'b1;
    #1 chk("rst_mid_fetch_outputs", out_vec(), 64'd0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    pmem[3] = 32'h0;
    run_line(10'd100, 0, 10'd0);
    chk("rst_first_line_done", 64'(done_at), 64'd17);
    chk("rst_overrun_clear", 64'(overrun), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
